// File: rtl/riscv_processor.sv
// riscv_processor: multi-cycle RV32I core, one instruction in flight at a time,
// sharing a single memory port for instruction fetch, loads and stores.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   resetn     asynchronous active-low reset
//   mem_addr   byte address: PC while fetching, rs1+imm during LOAD/STORE
//   mem_rdata  read data, valid the cycle after mem_rstrb
//   mem_rstrb  one-cycle read request (FETCH_INSTR and LOAD)
//   mem_wdata  store data, byte/halfword replicated across lanes
//   mem_wmask  byte-lane write enables, nonzero only in STORE
//
// Optional feature: define PROCESSOR_CYCLE_CSR_EN to add a 64-bit cycle
// counter readable through CSRRS cycle (0xC00) / cycleh (0xC80). Without it
// every SYSTEM instruction is a no-op.
//
// Cycles per instruction: 4 (ALU/branch/jump/LUI/AUIPC/SYSTEM), 5 (store),
// 6 (load).

module riscv_processor (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  typedef enum logic [2:0] {
    FETCH_INSTR, WAIT_INSTR, FETCH_REGS, EXECUTE, LOAD, WAIT_DATA, STORE
  } state_t;

  state_t      state;
  logic [31:0] pc, instr, rs1, rs2;
  logic [31:0] rf [0:31];   // entry 0 is never written; reads of x0 are muxed to 0

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_alu_reg, is_alu_imm, is_load, is_store, is_branch;
  logic        is_jal, is_jalr, is_lui, is_auipc, is_csr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign rd         = instr[11:7];
  assign is_alu_reg = (opcode == 7'b0110011);
  assign is_alu_imm = (opcode == 7'b0010011);
  assign is_load    = (opcode == 7'b0000011);
  assign is_store   = (opcode == 7'b0100011);
  assign is_branch  = (opcode == 7'b1100011);
  assign is_jal     = (opcode == 7'b1101111);
  assign is_jalr    = (opcode == 7'b1100111);
  assign is_lui     = (opcode == 7'b0110111);
  assign is_auipc   = (opcode == 7'b0010111);

  assign imm_i = {{21{instr[31]}}, instr[30:20]};
  assign imm_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // ------------------------------------------------------ cycle counter CSR
  logic [31:0] csr_val;
`ifdef PROCESSOR_CYCLE_CSR_EN
  logic [63:0] cycle;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cycle <= 64'd0;
    else         cycle <= cycle + 64'd1;
  end

  // CSRRS only; cycle is read-only so the rs1 set-bits are dropped.
  assign is_csr  = (opcode == 7'b1110011) && (funct3 == 3'b010) &&
                   ((instr[31:20] == 12'hC00) || (instr[31:20] == 12'hC80));
  // 0xC80 differs from 0xC00 only in csr bit 7 (instr[27]).
  assign csr_val = instr[27] ? cycle[63:32] : cycle[31:0];
`else
  assign is_csr  = 1'b0;
  assign csr_val = 32'd0;
`endif

  // -------------------------------------------------------------------- ALU
  logic [31:0] alu_in2, alu_out;
  logic [4:0]  shamt;

  assign alu_in2 = is_alu_reg ? rs2 : imm_i;
  assign shamt   = is_alu_reg ? rs2[4:0] : instr[24:20];

  always_comb begin
    alu_out = 32'd0;
    case (funct3)
      // instr[30] selects SUB only in the register form; in ADDI it is an imm bit
      3'b000: alu_out = (is_alu_reg && instr[30]) ? rs1 - alu_in2 : rs1 + alu_in2;
      3'b001: alu_out = rs1 << shamt;
      3'b010: alu_out = {31'd0, $signed(rs1) < $signed(alu_in2)};
      3'b011: alu_out = {31'd0, rs1 < alu_in2};
      3'b100: alu_out = rs1 ^ alu_in2;
      3'b101: alu_out = instr[30] ? 32'($signed(rs1) >>> shamt) : rs1 >> shamt;
      3'b110: alu_out = rs1 | alu_in2;
      3'b111: alu_out = rs1 & alu_in2;
      default: alu_out = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------- branches
  logic take;

  always_comb begin
    take = 1'b0;
    case (funct3)
      3'b000: take = (rs1 == rs2);
      3'b001: take = (rs1 != rs2);
      3'b100: take = ($signed(rs1) <  $signed(rs2));
      3'b101: take = ($signed(rs1) >= $signed(rs2));
      3'b110: take = (rs1 <  rs2);
      3'b111: take = (rs1 >= rs2);
      default: take = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4, next_pc, jalr_tgt;

  assign pc_plus4 = pc + 32'd4;
  assign jalr_tgt = rs1 + imm_i;

  always_comb begin
    next_pc = pc_plus4;
    if (is_jal)                  next_pc = pc + imm_j;
    else if (is_jalr)            next_pc = {jalr_tgt[31:1], 1'b0};
    else if (is_branch && take)  next_pc = pc + imm_b;
  end

  // --------------------------------------------------------- load / store
  logic [31:0] ls_addr, load_data, store_data;
  logic [15:0] load_half;
  logic [7:0]  load_byte;
  logic        load_sign;
  logic [3:0]  store_mask;

  assign ls_addr   = rs1 + (is_store ? imm_s : imm_i);
  assign load_half = ls_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign load_byte = ls_addr[0] ? load_half[15:8]  : load_half[7:0];
  // funct3[2] marks the unsigned variants (LBU/LHU)
  assign load_sign = !funct3[2] && (funct3[0] ? load_half[15] : load_byte[7]);

  always_comb begin
    case (funct3[1:0])
      2'b00:   load_data = {{24{load_sign}}, load_byte};
      2'b01:   load_data = {{16{load_sign}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{rs2[7:0]}};
        store_mask = 4'b0001 << ls_addr[1:0];
      end
      2'b01: begin
        store_data = {2{rs2[15:0]}};
        store_mask = ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = rs2;
        store_mask = 4'b1111;
      end
    endcase
  end

  // ------------------------------------------------------------- writeback
  logic [31:0] exec_data, wb_data;
  logic        wb_en;

  always_comb begin
    exec_data = alu_out;
    if (is_lui)                exec_data = imm_u;
    else if (is_auipc)         exec_data = pc + imm_u;
    else if (is_jal || is_jalr) exec_data = pc_plus4;
    else if (is_csr)           exec_data = csr_val;
  end

  assign wb_data = (state == WAIT_DATA) ? load_data : exec_data;
  assign wb_en   = (rd != 5'd0) &&
                   (((state == EXECUTE) &&
                     (is_alu_reg || is_alu_imm || is_lui || is_auipc ||
                      is_jal || is_jalr || is_csr)) ||
                    (state == WAIT_DATA));

  // Register file is deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && wb_en) rf[rd] <= wb_data;
  end

  // ---------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= FETCH_INSTR;
      pc    <= 32'd0;
      instr <= 32'd0;
      rs1   <= 32'd0;
      rs2   <= 32'd0;
    end else begin
      case (state)
        FETCH_INSTR: state <= WAIT_INSTR;
        WAIT_INSTR: begin
          instr <= mem_rdata;
          state <= FETCH_REGS;
        end
        FETCH_REGS: begin
          rs1   <= (instr[19:15] == 5'd0) ? 32'd0 : rf[instr[19:15]];
          rs2   <= (instr[24:20] == 5'd0) ? 32'd0 : rf[instr[24:20]];
          state <= EXECUTE;
        end
        EXECUTE: begin
          pc <= next_pc;
          if (is_load)       state <= LOAD;
          else if (is_store) state <= STORE;
          else               state <= FETCH_INSTR;
        end
        LOAD:      state <= WAIT_DATA;
        WAIT_DATA: state <= FETCH_INSTR;
        STORE:     state <= FETCH_INSTR;
        default:   state <= FETCH_INSTR;
      endcase
    end
  end

  // Strobes decode the registered state and are gated by resetn so an
  // asserted reset silences the port in the same cycle.
  assign mem_addr  = ((state == FETCH_INSTR) || (state == WAIT_INSTR)) ? pc : ls_addr;
  assign mem_rstrb = resetn && ((state == FETCH_INSTR) || (state == LOAD));
  assign mem_wmask = (resetn && (state == STORE)) ? store_mask : 4'b0000;
  assign mem_wdata = resetn ? store_data : 32'd0;

endmodule

// File: tb/tb_riscv_processor.sv
// Directed bench for riscv_processor. Programs are placed in a behavioural
// memory in execution order; each placement pushes the expected memory-port
// events (fetch/load reads and stores, with address, mask, data and cycle
// stamp) onto a scoreboard that a negedge monitor pops and compares.

module tb_riscv_processor;

  logic        clk;
  logic        resetn;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  riscv_processor dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rstrb (mem_rstrb),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only memory model: one-cycle read latency; stores are only scored.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct packed {
    logic [1:0]  kind;   // {read, write}
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  ev_t         sb[$];
  int          errors;
  int          checks;
  int          evn;
  int          mcyc;
  logic [31:0] pc_m, cyc_m;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------- monitor
  initial begin
    ev_t exp_e, obs_e;
    mcyc = 0;
    evn  = 0;
    forever begin
      @(negedge clk);
      if (!resetn) mcyc = 0;
      else begin
        if ((mem_rstrb || (|mem_wmask)) && sb.size() != 0) begin
          exp_e = sb.pop_front();
          obs_e = {mem_rstrb, |mem_wmask, mem_addr, mem_wmask,
                   (|mem_wmask) ? mem_wdata : 32'h0, 32'(mcyc)};
          check($sformatf("ev%0d", evn), 128'(obs_e), 128'(exp_e));
          evn++;
        end
        mcyc++;
      end
    end
  end

  // -------------------------------------------------------------- encoders
  localparam logic [6:0] OPI = 7'h13, LD = 7'h03, LUI = 7'h37, AUIPC = 7'h17,
                         JALR = 7'h67, SYS = 7'h73;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // ---------------------------------------------- placement + expectations
  task automatic put(input logic [31:0] w);
    ev_t e;
    mem[pc_m[9:2]] = w;
    e = {2'b10, pc_m, 4'h0, 32'h0, cyc_m};
    sb.push_back(e);
  endtask

  task automatic op_alu(input logic [31:0] w);
    put(w);
    cyc_m += 4;
    pc_m  += 4;
  endtask

  task automatic op_jmp(input logic [31:0] w, input logic [31:0] target);
    put(w);
    cyc_m += 4;
    pc_m  = target;
  endtask

  task automatic op_ld(input logic [31:0] w, input logic [31:0] a);
    ev_t e;
    put(w);
    e = {2'b10, a, 4'h0, 32'h0, cyc_m + 32'd4};
    sb.push_back(e);
    cyc_m += 6;
    pc_m  += 4;
  endtask

  task automatic op_st(input logic [31:0] w, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    ev_t e;
    put(w);
    e = {2'b01, a, m, d, cyc_m + 32'd4};
    sb.push_back(e);
    cyc_m += 5;
    pc_m  += 4;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 128'(sb.size()), 128'(0));
  endtask

  task automatic release_reset(input string tag);
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check({tag, "_rstrb"}, 128'(mem_rstrb), 128'(1'b1));
    check({tag, "_addr"},  128'(mem_addr),  128'(32'h0));
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] t, x1_val, x7_val, f20;
    resetn = 1'b0;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64] = 32'h8000_0000;   // word at 0x100

    // ---------------- program 1
    pc_m = 0; cyc_m = 0;
    op_alu(enc_i(12'd5,   5'd0, 3'b000, 5'd1, OPI));              // x1 = 5
    op_alu(enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, OPI));              // x2 = -2
    op_ld (enc_i(12'h103, 5'd0, 3'b000, 5'd4, LD), 32'h103);      // LB
    op_ld (enc_i(12'h103, 5'd0, 3'b100, 5'd5, LD), 32'h103);      // LBU
    op_ld (enc_i(12'h102, 5'd0, 3'b001, 5'd8, LD), 32'h102);      // LH
    op_st (enc_s(12'h100, 5'd2, 5'd0, 3'b010), 32'h100, 4'hF, 32'hFFFF_FFFE);
    op_st (enc_s(12'h104, 5'd4, 5'd0, 3'b010), 32'h104, 4'hF, 32'hFFFF_FF80);
    op_st (enc_s(12'h108, 5'd5, 5'd0, 3'b010), 32'h108, 4'hF, 32'h0000_0080);
    op_st (enc_s(12'h10C, 5'd8, 5'd0, 3'b010), 32'h10C, 4'hF, 32'hFFFF_8000);
    op_alu(enc_u(20'h12345, 5'd3, LUI));
    op_alu(enc_i(12'h678, 5'd3, 3'b000, 5'd3, OPI));              // x3 = 0x12345678
    op_st (enc_s(12'h113, 5'd3, 5'd0, 3'b000), 32'h113, 4'b1000, 32'h7878_7878);
    op_st (enc_s(12'h116, 5'd3, 5'd0, 3'b001), 32'h116, 4'b1100, 32'h5678_5678);
    op_alu(enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd9));               // SUB
    op_st (enc_s(12'h118, 5'd9, 5'd0, 3'b010), 32'h118, 4'hF, 32'h1234_5673);
    op_alu(enc_i(12'h404, 5'd4, 3'b101, 5'd10, OPI));             // SRAI 4
    op_st (enc_s(12'h11C, 5'd10, 5'd0, 3'b010), 32'h11C, 4'hF, 32'hFFFF_FFF8);
    op_alu(enc_i(12'h004, 5'd4, 3'b101, 5'd11, OPI));             // SRLI 4
    op_st (enc_s(12'h120, 5'd11, 5'd0, 3'b010), 32'h120, 4'hF, 32'h0FFF_FFF8);
    op_alu(enc_r(7'h00, 5'd1, 5'd4, 3'b010, 5'd12));              // SLT
    op_alu(enc_r(7'h00, 5'd1, 5'd4, 3'b011, 5'd13));              // SLTU
    op_st (enc_s(12'h124, 5'd12, 5'd0, 3'b010), 32'h124, 4'hF, 32'h1);
    op_st (enc_s(12'h128, 5'd13, 5'd0, 3'b010), 32'h128, 4'hF, 32'h0);
    op_alu(enc_i(12'h003, 5'd1, 3'b001, 5'd14, OPI));             // SLLI 3
    op_st (enc_s(12'h12C, 5'd14, 5'd0, 3'b010), 32'h12C, 4'hF, 32'h28);
    op_alu(enc_i(12'hFFF, 5'd3, 3'b100, 5'd15, OPI));             // XORI -1
    op_st (enc_s(12'h130, 5'd15, 5'd0, 3'b010), 32'h130, 4'hF, 32'hEDCB_A987);
    op_alu(enc_r(7'h00, 5'd1, 5'd5, 3'b110, 5'd16));              // OR
    op_alu(enc_r(7'h00, 5'd4, 5'd3, 3'b111, 5'd17));              // AND
    op_st (enc_s(12'h134, 5'd16, 5'd0, 3'b010), 32'h134, 4'hF, 32'h85);
    op_st (enc_s(12'h138, 5'd17, 5'd0, 3'b010), 32'h138, 4'hF, 32'h1234_5600);
    op_alu(enc_r(7'h00, 5'd1, 5'd3, 3'b101, 5'd23));              // SRL by x1=5
    op_alu(enc_r(7'h00, 5'd1, 5'd2, 3'b000, 5'd24));              // ADD wraps
    op_st (enc_s(12'h14C, 5'd23, 5'd0, 3'b010), 32'h14C, 4'hF, 32'h0091_A2B3);
    op_st (enc_s(12'h150, 5'd24, 5'd0, 3'b010), 32'h150, 4'hF, 32'h3);
    op_alu(enc_i(12'd1, 5'd0, 3'b000, 5'd0, OPI));                // x0 write ignored
    op_st (enc_s(12'h13C, 5'd0, 5'd0, 3'b010), 32'h13C, 4'hF, 32'h0);
    t = pc_m + 32'h1000;
    op_alu(enc_u(20'h00001, 5'd18, AUIPC));
    op_st (enc_s(12'h140, 5'd18, 5'd0, 3'b010), 32'h140, 4'hF, t);
    op_alu(enc_b(13'd8, 5'd2, 5'd1, 3'b000));                     // BEQ not taken
    op_jmp(enc_b(13'd8, 5'd2, 5'd1, 3'b001), pc_m + 32'd8);       // BNE taken
    t = pc_m;
    x1_val = t + 32'd4;
    op_jmp(enc_j(21'h1FFFFC, 5'd1), t - 32'd4);                   // JAL x1,-4
    op_jmp(enc_j(21'd8, 5'd0), t + 32'd4);                        // JAL x0,+8
    op_st (enc_s(12'h144, 5'd1, 5'd0, 3'b010), 32'h144, 4'hF, x1_val);
    op_alu(enc_i(12'h23F, 5'd0, 3'b000, 5'd6, OPI));
    x7_val = pc_m + 32'd4;
    op_jmp(enc_i(12'd2, 5'd6, 3'b000, 5'd7, JALR), 32'h240);      // 0x241 -> 0x240
    op_st (enc_s(12'h148, 5'd7, 5'd0, 3'b010), 32'h148, 4'hF, x7_val);
    op_alu(enc_i(12'h055, 5'd0, 3'b000, 5'd19, OPI));             // x19 = 0x55
    op_ld (enc_i(12'h100, 5'd0, 3'b010, 5'd19, LD), 32'h100);     // aborted LW

    repeat (3) @(posedge clk);
    #1;
    check("rst_rstrb", 128'(mem_rstrb), 128'(1'b0));
    check("rst_wmask", 128'(mem_wmask), 128'(4'h0));
    check("rst_addr",  128'(mem_addr),  128'(32'h0));
    check("rst_wdata", 128'(mem_wdata), 128'(32'h0));

    release_reset("rel1");
    drain("drain1");                     // returns mid-LOAD of the LW

    @(posedge clk);                      // now in WAIT_DATA
    #1 resetn = 1'b0;
    #1;
    check("abort_ld_rstrb", 128'(mem_rstrb), 128'(1'b0));
    check("abort_ld_wmask", 128'(mem_wmask), 128'(4'h0));
    check("abort_ld_addr",  128'(mem_addr),  128'(32'h0));

    // ---------------- program 2 (loaded while reset is held)
    pc_m = 0; cyc_m = 0;
    op_alu(enc_i(12'd7, 5'd0, 3'b000, 5'd20, OPI));
    op_alu(enc_i(12'd7, 5'd0, 3'b000, 5'd21, OPI));
    op_alu(enc_i(12'd9, 5'd0, 3'b000, 5'd25, OPI));
    op_st (enc_s(12'h200, 5'd19, 5'd0, 3'b010), 32'h200, 4'hF, 32'h55);
    f20 = cyc_m + 32'd3;                 // counter value seen in EXECUTE
    op_alu(enc_i(12'hC00, 5'd0, 3'b010, 5'd20, SYS));
    op_alu(enc_i(12'hC00, 5'd0, 3'b010, 5'd21, SYS));
    op_alu(enc_i(12'hC80, 5'd0, 3'b010, 5'd25, SYS));
    op_alu(enc_r(7'h20, 5'd20, 5'd21, 3'b000, 5'd22));
`ifdef PROCESSOR_CYCLE_CSR_EN
    op_st (enc_s(12'h204, 5'd22, 5'd0, 3'b010), 32'h204, 4'hF, 32'd4);
    op_st (enc_s(12'h208, 5'd20, 5'd0, 3'b010), 32'h208, 4'hF, f20);
    op_st (enc_s(12'h20C, 5'd25, 5'd0, 3'b010), 32'h20C, 4'hF, 32'd0);
`else
    op_st (enc_s(12'h204, 5'd22, 5'd0, 3'b010), 32'h204, 4'hF, 32'd0);
    op_st (enc_s(12'h208, 5'd20, 5'd0, 3'b010), 32'h208, 4'hF, 32'd7);
    op_st (enc_s(12'h20C, 5'd25, 5'd0, 3'b010), 32'h20C, 4'hF, 32'd9);
    f20 = 32'd7;
`endif
    op_st (enc_s(12'h210, 5'd1, 5'd0, 3'b010), 32'h210, 4'hF, x1_val);

    repeat (2) @(posedge clk);
    release_reset("rel2");
    drain("drain2");                     // returns mid-STORE of the last SW

    check("store_live_wmask", 128'(mem_wmask), 128'(4'hF));
    resetn = 1'b0;
    #1;
    check("abort_st_wmask", 128'(mem_wmask), 128'(4'h0));
    check("abort_st_rstrb", 128'(mem_rstrb), 128'(1'b0));
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
